// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM stage and MEM/WB pipeline register of a 5-stage MIPS
//               pipeline.
//               - Resolves branches combinationally (pc_src, branch_target).
//               - Runs data-memory loads/stores over a req/ready bus that
//                 may insert wait states. Accesses that outlast TIMEOUT_CYCLES
//                 are aborted and flagged.
//               - Stalls upstream stages while an access is outstanding.
//               - Holds the MEM/WB register feeding write-back.
//
// Ports       : clk, reset            - clock, synchronous active-high reset
//               alu_result .. branch_dst - EX/MEM register contents
//               pc_src, branch_target  - branch resolution to IF
//               stall                  - freezes PC, IF/ID, ID/EX, EX/MEM
//               dmem_*                 - data-memory bus (req/we/addr/wdata
//                                        registered; rdata/ready inputs)
//               wb_out .. wb_valid     - MEM/WB register contents
//               bus_err                - sticky access-timeout flag
//               misalign               - one-cycle trap pulse (optional)
//
// Parameters  : TIMEOUT_CYCLES - max BUSY cycles before abort (1..65535)
// Macros      : MISALIGN_TRAP_EN - adds the misalign output; misaligned
//                                  accesses are dropped instead of issued.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    // EX/MEM register
    input  logic [31:0] alu_result,
    input  logic [31:0] read_data2,
    input  logic [4:0]  write_dst,
    input  logic [1:0]  wb_in,
    input  logic        branch,
    input  logic        zero,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [29:0] branch_dst,
    // Branch resolution
    output logic        pc_src,
    output logic [29:0] branch_target,
    // Pipeline control
    output logic        stall,
    // Data-memory bus
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    // MEM/WB register
    output logic [1:0]  wb_out,
    output logic [31:0] mem_data,
    output logic [31:0] alu_out,
    output logic [4:0]  wb_dst,
    output logic        wb_valid,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        bus_err
);

    localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic [31:0] r_hold;

    logic        w_mem_op;
    logic        w_start;
    logic        w_ready_hit;
    logic        w_timeout;
    logic        w_capture;
`ifdef MISALIGN_TRAP_EN
    logic        w_misalign;
`else
    // Byte offset is meaningless when every access is treated as word-aligned.
    logic        w_unused;
    assign w_unused = &{1'b0, alu_result[1:0]};
`endif

    assign w_mem_op      = mem_read | mem_write;
    // Branches never carry a memory op, so no stall gating is needed here.
    assign pc_src        = branch & zero;
    assign branch_target = branch_dst;

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        w_start      = 1'b0;
        w_ready_hit  = 1'b0;
        w_timeout    = 1'b0;
        w_capture    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        w_misalign   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef MISALIGN_TRAP_EN
                if (w_mem_op && (alu_result[1:0] != 2'b00)) begin
                    // Dropped access: no request, no stall, bubble into WB.
                    w_misalign = 1'b1;
                end else
`endif
                if (w_mem_op) begin
                    stall        = 1'b1;
                    w_start      = 1'b1;
                    w_state_next = S_BUSY;
                end else begin
                    w_capture = 1'b1;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (dmem_ready) begin
                    w_ready_hit  = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Upstream inputs are still the stalled memory instruction.
                w_capture    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, timeout counter, bus interface, load hold register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_hold     <= 32'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 30'd0;
            dmem_wdata <= 32'd0;
            bus_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= 16'd0;
            end

            if (w_start) begin
                dmem_req   <= 1'b1;
                // Read and write together resolve to a write.
                dmem_we    <= mem_write;
                dmem_addr  <= alu_result[31:2];
                dmem_wdata <= read_data2;
            end else if (w_ready_hit || w_timeout) begin
                dmem_req <= 1'b0;
            end

            if (w_ready_hit) begin
                // Stores return nothing to write back.
                r_hold <= dmem_we ? 32'd0 : dmem_rdata;
            end else if (w_timeout) begin
                r_hold  <= 32'd0;
                bus_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_out   <= 2'b00;
            mem_data <= 32'd0;
            alu_out  <= 32'd0;
            wb_dst   <= 5'd0;
            wb_valid <= 1'b0;
        end else if (w_capture) begin
            wb_out   <= wb_in;
            alu_out  <= alu_result;
            wb_dst   <= write_dst;
            wb_valid <= 1'b1;
            if (r_state == S_DONE) begin
                mem_data <= r_hold;
            end
        end else begin
            // Stall or dropped access: insert a bubble, keep data fields.
            wb_out   <= 2'b00;
            wb_valid <= 1'b0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= w_misalign;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for mem_wb_stage. Runs with
//               TIMEOUT_CYCLES=4 so the abort path is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result;
    logic [31:0] read_data2;
    logic [4:0]  write_dst;
    logic [1:0]  wb_in;
    logic        branch;
    logic        zero;
    logic        mem_read;
    logic        mem_write;
    logic [29:0] branch_dst;
    logic        pc_src;
    logic [29:0] branch_target;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [1:0]  wb_out;
    logic [31:0] mem_data;
    logic [31:0] alu_out;
    logic [4:0]  wb_dst;
    logic        wb_valid;
    logic        bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    mem_wb_stage #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_result   (alu_result),
        .read_data2   (read_data2),
        .write_dst    (write_dst),
        .wb_in        (wb_in),
        .branch       (branch),
        .zero         (zero),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .branch_dst   (branch_dst),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .wb_out       (wb_out),
        .mem_data     (mem_data),
        .alu_out      (alu_out),
        .wb_dst       (wb_dst),
        .wb_valid     (wb_valid),
`ifdef MISALIGN_TRAP_EN
        .misalign     (misalign),
`endif
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        alu_result = 32'd0;
        read_data2 = 32'd0;
        write_dst  = 5'd0;
        wb_in      = 2'b00;
        branch     = 1'b0;
        zero       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch_dst = 30'd0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_bus_err",  32'(bus_err),  32'd0);
        chk("rst_stall",    32'(stall),    32'd0);
        chk("rst_mem_data", mem_data,      32'd0);

        // ALU op: single-cycle pass-through
        wb_in      = 2'b10;
        alu_result = 32'h0000_0010;
        write_dst  = 5'd5;
        #1;
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_wb_out",   32'(wb_out),   32'd2);
        chk("alu_alu_out",  alu_out,       32'h10);
        chk("alu_wb_dst",   32'(wb_dst),   32'd5);
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);

        // Load, zero wait states
        wb_in      = 2'b11;
        mem_read   = 1'b1;
        alu_result = 32'h0000_0100;
        write_dst  = 5'd7;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        chk("ld_stall_idle", 32'(stall), 32'd1);
        tick();                                   // BUSY
        chk("ld_req",        32'(dmem_req),  32'd1);
        chk("ld_we",         32'(dmem_we),   32'd0);
        chk("ld_addr",       32'(dmem_addr), 32'h40);
        chk("ld_stall_busy", 32'(stall),     32'd1);
        chk("ld_bubble1",    32'(wb_valid),  32'd0);
        dmem_ready = 1'b1;
        tick();                                   // DONE
        dmem_ready = 1'b0;
        chk("ld_req_drop",   32'(dmem_req),  32'd0);
        chk("ld_stall_done", 32'(stall),     32'd0);
        chk("ld_bubble2",    32'(wb_valid),  32'd0);
        tick();                                   // captured
        chk("ld_mem_data", mem_data,       32'hCAFE_F00D);
        chk("ld_wb_valid", 32'(wb_valid),  32'd1);
        chk("ld_wb_out",   32'(wb_out),    32'd3);
        chk("ld_wb_dst",   32'(wb_dst),    32'd7);

        // Store, 3 wait cycles; ready lands when the counter is at its limit
        nop();
        mem_write  = 1'b1;
        read_data2 = 32'h1234_5678;
        alu_result = 32'h0000_0200;
        tick();                                   // BUSY1
        chk("st_we",    32'(dmem_we),   32'd1);
        chk("st_wdata", dmem_wdata,     32'h1234_5678);
        chk("st_addr",  32'(dmem_addr), 32'h80);
        for (int i = 2; i <= 4; i++) begin
            tick();                               // BUSY2..BUSY4
            chk($sformatf("st_req_busy%0d", i), 32'(dmem_req), 32'd1);
            chk($sformatf("st_stall_busy%0d", i), 32'(stall), 32'd1);
        end
        dmem_ready = 1'b1;
        tick();                                   // DONE
        dmem_ready = 1'b0;
        chk("st_req_drop",   32'(dmem_req), 32'd0);
        chk("st_stall_done", 32'(stall),    32'd0);
        chk("st_no_err",     32'(bus_err),  32'd0);
        tick();
        chk("st_wb_valid", 32'(wb_valid), 32'd1);

        // Load timeout: ready never asserted
        nop();
        wb_in      = 2'b11;
        mem_read   = 1'b1;
        alu_result = 32'h0000_0300;
        dmem_rdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            tick();                               // BUSY1..BUSY4
            chk($sformatf("to_req_busy%0d", i), 32'(dmem_req), 32'd1);
            chk($sformatf("to_err_busy%0d", i), 32'(bus_err), 32'd0);
        end
        tick();                                   // DONE
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_bus_err",  32'(bus_err),  32'd1);
        chk("to_stall",    32'(stall),    32'd0);
        tick();
        chk("to_mem_data", mem_data,      32'd0);
        chk("to_wb_valid", 32'(wb_valid), 32'd1);
        nop();
        tick();
        tick();
        chk("to_err_sticky", 32'(bus_err), 32'd1);

        // Branch resolution (combinational)
        branch     = 1'b1;
        zero       = 1'b1;
        branch_dst = 30'h0000_0040;
        #1;
        chk("br_taken",  32'(pc_src),        32'd1);
        chk("br_target", 32'(branch_target), 32'h40);
        zero = 1'b0;
        #1;
        chk("br_not_taken", 32'(pc_src), 32'd0);
        nop();
        tick();

        // Reset during the 2nd wait cycle
        mem_read   = 1'b1;
        alu_result = 32'h0000_0400;
        tick();                                   // BUSY1
        tick();                                   // BUSY2
        chk("rb_req_before", 32'(dmem_req), 32'd1);
        reset    = 1'b1;
        mem_read = 1'b0;
        tick();
        reset = 1'b0;
        chk("rb_req",      32'(dmem_req), 32'd0);
        chk("rb_stall",    32'(stall),    32'd0);
        chk("rb_wb_valid", 32'(wb_valid), 32'd0);
        chk("rb_bus_err",  32'(bus_err),  32'd0);
        tick();
        chk("rb_req_idle", 32'(dmem_req), 32'd0);

`ifdef MISALIGN_TRAP_EN
        // Misaligned load is dropped and trapped
        wb_in      = 2'b11;
        mem_read   = 1'b1;
        alu_result = 32'h0000_0102;
        #1;
        chk("ma_stall", 32'(stall), 32'd0);
        tick();
        chk("ma_pulse",    32'(misalign), 32'd1);
        chk("ma_req",      32'(dmem_req), 32'd0);
        chk("ma_wb_valid", 32'(wb_valid), 32'd0);
        chk("ma_wb_out",   32'(wb_out),   32'd0);
        nop();
        tick();
        chk("ma_pulse_end", 32'(misalign), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
